// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states and RISC-V funct3 encodings.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arbState_e;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // SLL and SRL/SRA are the only multi-cycle functions of the serial shifter.
   function automatic logic isShift(input logic [2:0] funct3);
      return funct3[1:0] == 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer wins, wrapping around.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grantIdx,
   output logic               grantValid
);

   logic [IDW-1:0] cand;

   always_comb begin
      grant      = '0;
      grantIdx   = '0;
      grantValid = 1'b0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDW'((int'(ptr) + i) % NUM_REQ);
         if (!grantValid && req[cand]) begin
            grantValid  = 1'b1;
            grantIdx    = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one serial ALU among NUM_REQ requesters: round-robin accept, one operation
// in flight, timeout abort with an ALU reset pulse, and a held response.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 40,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ-1:0][31:0] req_arg1_i,
   input  logic [NUM_REQ-1:0][31:0] req_arg2_i,
   input  logic [NUM_REQ-1:0][2:0]  req_funct3_i,
   input  logic [NUM_REQ-1:0]       req_subsr_i,
   output logic [31:0]              alu_arg1_o,
   output logic [31:0]              alu_arg2_o,
   output logic [2:0]               alu_funct3_o,
   output logic                     alu_subsr_o,
   output logic                     alu_rst_o,
   input  logic [31:0]              alu_res_i,
   input  logic                     alu_done_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [IDW-1:0]           rsp_id_o,
   output logic [31:0]              rsp_data_o,
   output logic                     rsp_err_o
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   arbState_e      state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] opId;
   logic [CW-1:0]  busyCnt;
   logic           timeoutPulse;

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     grantIdx;
   logic               grantValid;
   logic [IDW-1:0]     ptrNext;
   logic               doneSeen;
   logic               timedOut;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) rrArb (
      .req        (req_valid_i),
      .ptr        (ptr),
      .grant      (grant),
      .grantIdx   (grantIdx),
      .grantValid (grantValid)
   );

   assign req_ready_o = (rst_ni && state == IDLE) ? grant : '0;
   assign alu_rst_o   = ~rst_ni | timeoutPulse;
   assign ptrNext     = (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + IDW'(1);

   // The shifter spends its first BUSY cycle loading, so any done seen there is bogus.
   assign doneSeen = alu_done_i && !(busyCnt == '0 && isShift(alu_funct3_o));
   assign timedOut = busyCnt == CW'(TIMEOUT_CYC - 1);

   // Operand outputs double as the latched operation and are forced to zero outside
   // BUSY so the ALU never sees a shift it was not asked for.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         ptr          <= '0;
         opId         <= '0;
         busyCnt      <= '0;
         timeoutPulse <= 1'b0;
         alu_arg1_o   <= '0;
         alu_arg2_o   <= '0;
         alu_funct3_o <= '0;
         alu_subsr_o  <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_id_o     <= '0;
         rsp_data_o   <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         timeoutPulse <= 1'b0;
         case (state)
            IDLE: begin
               if (grantValid) begin
                  state        <= BUSY;
                  opId         <= grantIdx;
                  ptr          <= ptrNext;
                  busyCnt      <= '0;
                  alu_arg1_o   <= req_arg1_i[grantIdx];
                  alu_arg2_o   <= req_arg2_i[grantIdx];
                  alu_funct3_o <= req_funct3_i[grantIdx];
                  alu_subsr_o  <= req_subsr_i[grantIdx];
               end
            end
            BUSY: begin
               if (doneSeen || timedOut) begin
                  state        <= RESP;
                  rsp_valid_o  <= 1'b1;
                  rsp_id_o     <= opId;
                  rsp_data_o   <= doneSeen ? alu_res_i : 32'd0;
                  rsp_err_o    <= !doneSeen;
                  timeoutPulse <= !doneSeen;
                  busyCnt      <= '0;
                  alu_arg1_o   <= '0;
                  alu_arg2_o   <= '0;
                  alu_funct3_o <= '0;
                  alu_subsr_o  <= 1'b0;
               end else begin
                  busyCnt <= busyCnt + CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural serial-shift ALU and a response scoreboard.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int NREQ = 2;
   localparam int TOUT = 40;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ-1:0]       req_ready_o;
   logic [NREQ-1:0][31:0] req_arg1_i;
   logic [NREQ-1:0][31:0] req_arg2_i;
   logic [NREQ-1:0][2:0]  req_funct3_i;
   logic [NREQ-1:0]       req_subsr_i;
   logic [31:0]           alu_arg1_o;
   logic [31:0]           alu_arg2_o;
   logic [2:0]            alu_funct3_o;
   logic                  alu_subsr_o;
   logic                  alu_rst_o;
   logic [31:0]           alu_res_i;
   logic                  alu_done_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [0:0]            rsp_id_o;
   logic [31:0]           rsp_data_o;
   logic                  rsp_err_o;

   typedef struct {
      logic [0:0]  id;
      logic [31:0] data;
      logic        err;
   } expRsp_t;

   expRsp_t sbQ[$];
   int nCompared   = 0;
   int nMismatched = 0;

   logic       stuckDone;
   logic       earlyDone;
   logic       shActive;
   logic [4:0] shCnt;
   logic       aluIsShift;

   alu_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_arg1_i   (req_arg1_i),
      .req_arg2_i   (req_arg2_i),
      .req_funct3_i (req_funct3_i),
      .req_subsr_i  (req_subsr_i),
      .alu_arg1_o   (alu_arg1_o),
      .alu_arg2_o   (alu_arg2_o),
      .alu_funct3_o (alu_funct3_o),
      .alu_subsr_o  (alu_subsr_o),
      .alu_rst_o    (alu_rst_o),
      .alu_res_i    (alu_res_i),
      .alu_done_i   (alu_done_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_o     (rsp_id_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_err_o    (rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f, input logic s);
      logic [31:0] r;
      case (f)
         3'b000:  r = s ? a - b : a + b;
         3'b001:  r = a << b[4:0];
         3'b010:  r = {31'd0, $signed(a) < $signed(b)};
         3'b011:  r = {31'd0, a < b};
         3'b100:  r = a ^ b;
         3'b101:  r = s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // Serial ALU model: one load cycle, then n shift cycles; other functions finish at once.
   assign aluIsShift = alu_funct3_o[1:0] == 2'b01;
   assign alu_res_i  = aluFn(alu_arg1_o, alu_arg2_o, alu_funct3_o, alu_subsr_o);
   assign alu_done_i = stuckDone ? 1'b0 :
                       aluIsShift ? (shActive ? shCnt == 5'd0 : earlyDone) : 1'b1;

   always_ff @(posedge clk_i) begin
      if (alu_rst_o) begin
         shActive <= 1'b0;
         shCnt    <= 5'd0;
      end else if (!shActive && aluIsShift) begin
         shActive <= 1'b1;
         shCnt    <= alu_arg2_o[4:0];
      end else if (shActive) begin
         if (shCnt == 5'd0) shActive <= 1'b0;
         else               shCnt    <= shCnt - 5'd1;
      end
   end

   task automatic applyStimulus(input logic [0:0] k, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f, input logic s);
      @(negedge clk_i);
      req_arg1_i[k]   = a;
      req_arg2_i[k]   = b;
      req_funct3_i[k] = f;
      req_subsr_i[k]  = s;
      req_valid_i[k]  = 1'b1;
      @(posedge clk_i);
      #1 req_valid_i[k] = 1'b0;
   endtask

   task automatic waitRsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!rsp_valid_o && lat < 100);
   endtask

   task automatic test_reset;
      rst_ni       = 1'b0;
      req_valid_i  = 2'b11;
      req_arg1_i   = '0;
      req_arg2_i   = '0;
      req_funct3_i = '0;
      req_subsr_i  = '0;
      rsp_ready_i  = 1'b1;
      stuckDone    = 1'b0;
      earlyDone    = 1'b0;
      repeat (3) @(negedge clk_i);
      nCompared++;
      if (req_ready_o !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL reset_ready: got %b expected 00", req_ready_o);
      end
      nCompared++;
      if (rsp_valid_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o);
      end
      nCompared++;
      if ({rsp_id_o, rsp_data_o, rsp_err_o} !== 34'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_rsp_fields: got id=%h data=%h err=%b expected zeros",
                  rsp_id_o, rsp_data_o, rsp_err_o);
      end
      nCompared++;
      if ({alu_arg1_o, alu_arg2_o, alu_funct3_o, alu_subsr_o} !== 68'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_alu_outs: got %h %h %b %b expected zeros",
                  alu_arg1_o, alu_arg2_o, alu_funct3_o, alu_subsr_o);
      end
      nCompared++;
      if (alu_rst_o !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL reset_alu_rst: got %b expected 1", alu_rst_o);
      end
      rst_ni      = 1'b1;
      req_valid_i = 2'b00;
      @(negedge clk_i);
      nCompared++;
      if (alu_rst_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL release_alu_rst: got %b expected 0", alu_rst_o);
      end
   endtask

   task automatic test_add_latency;
      expRsp_t exp;
      int lat;
      @(negedge clk_i);
      req_arg1_i[0] = 32'd5; req_arg2_i[0] = 32'd7; req_funct3_i[0] = F3_ADD; req_subsr_i[0] = 1'b0;
      req_valid_i[0] = 1'b1;
      sbQ.push_back('{id: 1'b0, data: 32'd12, err: 1'b0});
      #1;
      nCompared++;
      if (req_ready_o !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL add_ready: got %b expected 01", req_ready_o);
      end
      @(posedge clk_i);
      #1 req_valid_i[0] = 1'b0;
      waitRsp(lat);
      nCompared++;
      if (lat !== 2) begin
         nMismatched++;
         $display("[TB] FAIL add_latency: got %0d expected 2", lat);
      end
      exp = sbQ.pop_front();
      nCompared++;
      if ({rsp_id_o, rsp_data_o, rsp_err_o} !== {exp.id, exp.data, exp.err}) begin
         nMismatched++;
         $display("[TB] FAIL add_rsp: got id=%h data=%h err=%b expected id=%h data=%h err=%b",
                  rsp_id_o, rsp_data_o, rsp_err_o, exp.id, exp.data, exp.err);
      end
      @(negedge clk_i);
      nCompared++;
      if (rsp_valid_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL add_rsp_drop: got %b expected 0", rsp_valid_o);
      end
   endtask

   task automatic test_sra_latency;
      expRsp_t exp;
      int lat;
      logic stable;
      earlyDone = 1'b1;
      stable    = 1'b1;
      sbQ.push_back('{id: 1'b1, data: 32'hF800_0000, err: 1'b0});
      applyStimulus(1'b1, 32'h8000_0000, 32'd4, F3_SR, 1'b1);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
         if (!rsp_valid_o && (alu_arg1_o !== 32'h8000_0000 || alu_arg2_o !== 32'd4 ||
                              alu_funct3_o !== F3_SR || alu_subsr_o !== 1'b1 || req_ready_o !== 2'b00))
            stable = 1'b0;
      end while (!rsp_valid_o && lat < 100);
      earlyDone = 1'b0;
      nCompared++;
      if (stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL sra_busy_hold: got %b expected 1", stable);
      end
      nCompared++;
      if (lat !== 7) begin
         nMismatched++;
         $display("[TB] FAIL sra_latency: got %0d expected 7", lat);
      end
      exp = sbQ.pop_front();
      nCompared++;
      if ({rsp_id_o, rsp_data_o, rsp_err_o} !== {exp.id, exp.data, exp.err}) begin
         nMismatched++;
         $display("[TB] FAIL sra_rsp: got id=%h data=%h err=%b expected id=%h data=%h err=%b",
                  rsp_id_o, rsp_data_o, rsp_err_o, exp.id, exp.data, exp.err);
      end
      nCompared++;
      if ({alu_arg1_o, alu_funct3_o} !== 35'd0) begin
         nMismatched++;
         $display("[TB] FAIL sra_resp_alu_idle: got %h %b expected zeros", alu_arg1_o, alu_funct3_o);
      end
   endtask

   task automatic test_round_robin;
      expRsp_t exp;
      int w;
      logic [0:0] expId;
      @(negedge clk_i);
      req_arg1_i[0] = 32'h0000_F0F0; req_arg2_i[0] = 32'h0000_0FF0; req_funct3_i[0] = F3_XOR;
      req_arg1_i[1] = 32'h0000_1234; req_arg2_i[1] = 32'h0000_FFFF; req_funct3_i[1] = F3_XOR;
      req_subsr_i   = 2'b00;
      req_valid_i   = 2'b11;
      for (int i = 0; i < 4; i++) begin
         expId = 1'(i % 2);
         sbQ.push_back('{id: expId, data: (expId == 1'b0) ? 32'h0000_FF00 : 32'h0000_EDCB, err: 1'b0});
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         expId = 1'(i % 2);
         for (w = 0; w < 20 && req_ready_o == 2'b00; w++) @(negedge clk_i);
         nCompared++;
         if (req_ready_o !== (2'b01 << expId)) begin
            nMismatched++;
            $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, req_ready_o, 2'b01 << expId);
         end
         @(posedge clk_i);
         w = 0;
         do begin
            @(negedge clk_i);
            w++;
         end while (!rsp_valid_o && w < 60);
         nCompared++;
         if (req_ready_o !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL rr_resp_ready%0d: got %b expected 00", i, req_ready_o);
         end
         exp = sbQ.pop_front();
         nCompared++;
         if ({rsp_id_o, rsp_data_o, rsp_err_o} !== {exp.id, exp.data, exp.err}) begin
            nMismatched++;
            $display("[TB] FAIL rr_rsp%0d: got id=%h data=%h err=%b expected id=%h data=%h err=%b",
                     i, rsp_id_o, rsp_data_o, rsp_err_o, exp.id, exp.data, exp.err);
         end
         if (i == 3) req_valid_i = 2'b00;
         @(negedge clk_i);
      end
   endtask

   task automatic test_timeout;
      expRsp_t exp;
      int lat;
      int rstCount;
      stuckDone = 1'b1;
      rstCount  = 0;
      sbQ.push_back('{id: 1'b0, data: 32'd0, err: 1'b1});
      applyStimulus(1'b0, 32'd1, 32'd2, F3_ADD, 1'b0);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
         if (alu_rst_o) rstCount++;
      end while (!rsp_valid_o && lat < 100);
      exp = sbQ.pop_front();
      nCompared++;
      if ({rsp_id_o, rsp_data_o, rsp_err_o} !== {exp.id, exp.data, exp.err}) begin
         nMismatched++;
         $display("[TB] FAIL timeout_rsp: got id=%h data=%h err=%b expected id=%h data=%h err=%b",
                  rsp_id_o, rsp_data_o, rsp_err_o, exp.id, exp.data, exp.err);
      end
      nCompared++;
      if (lat !== TOUT + 1) begin
         nMismatched++;
         $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, TOUT + 1);
      end
      repeat (3) begin
         @(negedge clk_i);
         if (alu_rst_o) rstCount++;
      end
      nCompared++;
      if (rstCount !== 1) begin
         nMismatched++;
         $display("[TB] FAIL timeout_alu_rst_pulse: got %0d cycles expected 1", rstCount);
      end
      stuckDone = 1'b0;
   endtask

   task automatic test_backpressure;
      expRsp_t exp;
      int lat;
      logic holdOk;
      rsp_ready_i = 1'b0;
      holdOk      = 1'b1;
      sbQ.push_back('{id: 1'b1, data: 32'h00FF_000F, err: 1'b0});
      applyStimulus(1'b1, 32'h00FF_0000, 32'h0000_000F, F3_OR, 1'b0);
      waitRsp(lat);
      exp = sbQ.pop_front();
      req_valid_i = 2'b01;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (rsp_valid_o !== 1'b1 || req_ready_o !== 2'b00 ||
             {rsp_id_o, rsp_data_o, rsp_err_o} !== {exp.id, exp.data, exp.err})
            holdOk = 1'b0;
         @(negedge clk_i);
      end
      nCompared++;
      if (holdOk !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL bp_hold: got %b expected 1 (last id=%h data=%h err=%b ready=%b)",
                  holdOk, rsp_id_o, rsp_data_o, rsp_err_o, req_ready_o);
      end
      req_valid_i = 2'b00;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      nCompared++;
      if (rsp_valid_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL bp_release: got %b expected 0", rsp_valid_o);
      end
      req_valid_i = 2'b01;
      #1;
      nCompared++;
      if (req_ready_o !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL bp_idle_ready: got %b expected 01", req_ready_o);
      end
      req_valid_i = 2'b00;
   endtask

   task automatic test_reset_mid_op;
      int seen;
      applyStimulus(1'b0, 32'd1, 32'd20, F3_SLL, 1'b0);
      repeat (4) @(negedge clk_i);
      nCompared++;
      if (alu_funct3_o !== F3_SLL) begin
         nMismatched++;
         $display("[TB] FAIL mid_busy_funct3: got %b expected 001", alu_funct3_o);
      end
      rst_ni = 1'b0;
      #1;
      nCompared++;
      if ({rsp_valid_o, alu_funct3_o, alu_arg1_o, alu_arg2_o, alu_rst_o} !== {1'b0, 3'b000, 64'd0, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL mid_reset_outs: got valid=%b f3=%b a1=%h a2=%h rst=%b expected 0 000 0 0 1",
                  rsp_valid_o, alu_funct3_o, alu_arg1_o, alu_arg2_o, alu_rst_o);
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      seen   = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (rsp_valid_o) seen++;
      end
      nCompared++;
      if (seen !== 0) begin
         nMismatched++;
         $display("[TB] FAIL mid_no_rsp: got %0d response cycles expected 0", seen);
      end
      req_valid_i = 2'b11;
      #1;
      nCompared++;
      if (req_ready_o !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL mid_ptr_reset: got %b expected 01", req_ready_o);
      end
      req_valid_i = 2'b00;
      nCompared++;
      if (sbQ.size() !== 0) begin
         nMismatched++;
         $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sbQ.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_sra_latency();
      test_round_robin();
      test_timeout();
      test_backpressure();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the ALU (legal 2..4).
REQ-002 Parameter TIMEOUT_CYC, default 40, maximum BUSY cycles before abort (must exceed 33).
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 req_valid_i  in  NUM_REQ  per-requester operation request.
REQ-006 req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-007 req_arg1_i / req_arg2_i  in  NUM_REQ x 32  per-requester operands.
REQ-008 req_funct3_i  in  NUM_REQ x 3  per-requester ALU function.
REQ-009 req_subsr_i  in  NUM_REQ  per-requester sub/arithmetic-shift select.
REQ-010 alu_arg1_o / alu_arg2_o  out  32  operands driven to the ALU.
REQ-011 alu_funct3_o  out  3  function driven to the ALU.
REQ-012 alu_subsr_o  out  1  sub/SRA select driven to the ALU.
REQ-013 alu_rst_o  out  1  active-high ALU reset.
REQ-014 alu_res_i  in  32  ALU result; alu_done_i  in  1  ALU done.
REQ-015 rsp_valid_o  out  1  response available; rsp_ready_i  in  1  response consumed.
REQ-016 rsp_id_o  out  clog2(NUM_REQ)  index of served requester; rsp_data_o  out  32  result; rsp_err_o  out  1  timeout flag.

Function
REQ-017 FSM states: IDLE, BUSY, RESP; transitions only on clk_i rising edge.
REQ-018 IDLE: req_ready_o is one-hot on the first valid requester at or after the round-robin pointer; all zero if no request.
REQ-019 Request k accepted when req_valid_i[k] and req_ready_o[k]; its arg1, arg2, funct3, subsr and k latched; next state BUSY; pointer becomes (k+1) mod NUM_REQ.
REQ-020 req_ready_o is zero in BUSY and RESP; no second operation is in flight.
REQ-021 BUSY: alu_* outputs driven from the latched operation, held constant for the whole BUSY period.
REQ-022 IDLE and RESP: alu_funct3_o=000, alu_subsr_o=0, alu_arg1_o=alu_arg2_o=0, so the ALU shifter never starts spuriously.
REQ-023 BUSY with alu_done_i=1: alu_res_i captured into rsp_data_o, rsp_err_o=0, next state RESP.
REQ-024 Latency: accept at cycle T; non-shift op gives rsp_valid_o at T+2; shift by n (0..31) gives rsp_valid_o at T+3+n.
REQ-025 Done is ignored in the first BUSY cycle for shift ops (funct3 001/101); the ALU's done is zero there by construction.
REQ-026 BUSY counter increments each BUSY cycle; at TIMEOUT_CYC without done: rsp_data_o=0, rsp_err_o=1, next state RESP, alu_rst_o pulsed for exactly one cycle.
REQ-027 RESP: rsp_valid_o=1 with stable rsp_id_o/data/err until rsp_valid_o and rsp_ready_i, then IDLE.
REQ-028 A requester that stays valid after RESP is re-arbitrated normally; no same-cycle accept in RESP.
REQ-029 alu_rst_o = ~rst_ni OR timeout pulse.

Reset
REQ-030 While rst_ni=0: state IDLE, pointer 0, counter 0, req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_err_o=0, alu_* outputs 0, alu_rst_o=1.
REQ-031 Reset mid-BUSY or mid-RESP discards the operation; no response is produced for it.

Structure
REQ-032 Shared package alu_arb_pkg holds the state enum and the funct3 constants (ADD 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111).
REQ-033 One sub-module rr_arbiter (NUM_REQ-wide round-robin grant from request vector and pointer); everything else stays in alu_arbiter.

Verification
REQ-034 Req0 ADD 5+7, rsp_ready_i=1 -> rsp_valid_o at T+2, rsp_data_o=12, rsp_id_o=0, rsp_err_o=0.
REQ-035 Req1 SRA arg1=0x80000000, arg2=4, subsr=1 -> rsp_valid_o at T+7, rsp_data_o=0xF8000000.
REQ-036 Req0 and req1 held valid continuously, XOR ops -> grants alternate 0,1,0,1 and the pointer wraps.
REQ-037 Model ALU with done stuck low, TIMEOUT_CYC=40 -> rsp_err_o=1, rsp_data_o=0 after 40 BUSY cycles, one-cycle alu_rst_o pulse.
REQ-038 rsp_ready_i=0 for 5 cycles in RESP -> outputs stable, req_ready_o=0, then IDLE on handshake.
REQ-039 rst_ni low during SLL by 20 -> all outputs at reset values immediately, no response after release.
